// File: rtl/siso_tx_sched_if.sv
// Handshake and serial-output bundle for siso_tx_sched.
// master = producer/link side, slave = scheduler side.
interface siso_tx_sched_if #(
    parameter int WIDTH = 4
) ();
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             sout;
    logic             sout_valid;
    logic             sof;
    logic             eof;
    logic             grant_id;
    logic             busy;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, sout, sout_valid, sof, eof, grant_id, busy
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, sout, sout_valid, sof, eof, grant_id, busy
    );
endinterface

// File: rtl/siso_tx_sched.sv
// Two-requester round-robin scheduler feeding an LSB-first SISO shift register.
// Define SISO_TX_PARITY_EN to append an even-parity bit to every frame.
module siso_tx_sched #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input logic            clk,
    input logic            rst,
    siso_tx_sched_if.slave bus
);

`ifdef SISO_TX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = (FRAME > 2) ? $clog2(FRAME) : 1;
    localparam int GAP_W = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_t;

    state_t           state;
    logic [FRAME-1:0] sr;
    logic [CNT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_grant;
    logic             grant_q;

    logic             sel1;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic [FRAME-1:0] load_word;
    logic             shifting;

    // Requester 1 wins if it is alone, or if both are valid and 0 went last.
    assign sel1     = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    assign bus.req0_ready = (state == StIdle) & ~rst & bus.req0_valid & ~sel1;
    assign bus.req1_ready = (state == StIdle) & ~rst & sel1;
    assign accept   = bus.req0_ready | bus.req1_ready;
    assign sel_data = sel1 ? bus.req1_data : bus.req0_data;

`ifdef SISO_TX_PARITY_EN
    // Parity rides above the data so the same shift path emits it last.
    assign load_word = {^sel_data, sel_data};
`else
    assign load_word = sel_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            sr         <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        sr         <= load_word;
                        grant_q    <= sel1;
                        last_grant <= sel1;
                        bit_cnt    <= '0;
                        state      <= StShift;
                    end
                end
                StShift: begin
                    sr <= {1'b0, sr[FRAME-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                        if (GAP > 0) state <= StGap;
                        else         state <= StIdle;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                StGap: begin
                    if (gap_cnt == GAP_LAST) state <= StIdle;
                    else                     gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign shifting       = (state == StShift);
    assign bus.sout       = shifting & sr[0];
    assign bus.sout_valid = shifting;
    assign bus.sof        = shifting & (bit_cnt == '0);
    assign bus.eof        = shifting & (bit_cnt == BIT_LAST);
    assign bus.busy       = (state != StIdle);
    assign bus.grant_id   = grant_q;

endmodule

// File: doc/siso_tx_sched.md
Name: siso_tx_sched

Overview:
- Two-requester serial transmit scheduler built around a WIDTH-bit right-shifting SISO register.
- Round-robin arbitration between two parallel-word sources. The granted word is loaded into the internal shift register and shifted out LSB-first on sout.
- Frame framing strobes are provided, plus a programmable idle gap between frames.
- Sits between parallel producers and a single serial link or serial memory input.

Parameters:
- WIDTH, 4, bits per data word / shift register length (2..32).
- GAP, 1, idle cycles forced between consecutive frames (0..15).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle when valid&&ready.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 handshake ready.
- sout  output  1  serial data, LSB first.
- sout_valid  output  1  sout carries a frame bit.
- sof  output  1  first bit of frame.
- eof  output  1  last bit of frame.
- grant_id  output  1  requester owning the current/last frame.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Reset, synchronous, active-high, reset rst; clock clk:
  - state=IDLE; shift register=0; bit counter=0; gap counter=0; last_grant=1, so requester 0 wins the first contention.
  - All outputs 0.
  - Reset mid-frame aborts immediately; no remaining bits are emitted.
- States:
  - IDLE: no frame in progress.
  - SHIFT: WIDTH cycles, one bit per cycle.
  - GAP: GAP cycles.
- Arbitration (IDLE only, combinational):
  - Only one valid: that requester is selected.
  - Both valid: select the requester != last_grant.
  - Exactly one reqN_ready is high in IDLE, and only for the selected requester, only when its valid is high. Both ready signals are 0 outside IDLE.
  - ready must not depend on the other requester's data.
- Handshake: valid&&ready in IDLE at cycle N:
  - shift register <= reqN_data; grant_id <= N; last_grant <= N; state -> SHIFT at N+1.
  - Requesters must hold data stable while valid is high and ready is low.
- SHIFT:
  - sout = sr[0]; sout_valid=1.
  - Each cycle sr <= {1'b0, sr[WIDTH-1:1]} and counter increments.
  - sof=1 on counter 0; eof=1 on counter WIDTH-1.
  - After the eof cycle: state -> GAP if GAP>0, else IDLE.
- GAP: sout=0, sout_valid=0, counts GAP cycles, then -> IDLE.
- Latency:
  - Accept at cycle N gives first bit at N+1 and last bit at N+WIDTH.
  - Next accept no earlier than N+WIDTH+GAP+1.
- sout=0 whenever sout_valid=0.
- busy=1 in SHIFT/GAP.
- grant_id holds its value until the next grant.
- A valid deasserting in IDLE before ready is a protocol violation; the design just re-arbitrates each cycle.
- Counter widths: clog2 of WIDTH and GAP respectively, minimum 1.

Optional Feature:
- SISO_TX_PARITY_EN defined:
  - An even-parity bit (XOR of the accepted word) is captured at load.
  - That bit is emitted after the WIDTH data bits, so SHIFT lasts WIDTH+1 cycles.
  - eof asserts on the parity bit, not on the last data bit.
- SISO_TX_PARITY_EN undefined: no parity logic; frame is WIDTH bits exactly.

Test Plan:
- Single request: reset, then req0_valid=1 with data 4'b1011 at cycle 2.
  - req0_ready=1 at cycle 2.
  - sout = 1,1,0,1 at cycles 3-6, sof at 3, eof at 6.
  - busy through cycle 7 (GAP=1); IDLE at 8.
- Contention after reset: both valid, data0=4'hA, data1=4'h5.
  - Requester 0 granted first, sout 0,1,0,1.
  - Then requester 1 granted at next IDLE, sout 1,0,1,0; grant_id 0 then 1.
- Fairness: both held valid for 4 frames -> grants alternate 0,1,0,1; no requester served twice in a row.
- Reset mid-frame: rst asserted during the 2nd bit.
  - Next cycle all outputs 0 and state IDLE.
  - A pending req1 is then accepted as a fresh frame with sof on its first bit.
- Back-pressure: req1_valid held while a frame is in SHIFT.
  - req1_ready stays 0 during SHIFT and GAP.
  - Data is accepted in the first IDLE cycle.
- With SISO_TX_PARITY_EN, data 4'b0111 -> sout 1,1,1,0 then parity 1; eof on the 5th bit.
